// File: rtl/dma_rd_req_gen.sv
// Splits DMA read descriptors into PCIe Memory Read request TLP headers on an AXIS
// stream. Chunks respect MRRS and 4 KB boundaries; tags come from a 32-entry free pool.
module dma_rd_req_gen #(
  parameter int AXI_DATA_WIDTH = 128,
  parameter int BE_WIDTH       = AXI_DATA_WIDTH / 8,
  parameter int USER_WIDTH_TX  = 4,
  parameter int TAG_WIDTH      = 5
) (
  input  logic                      axi_clk,
  input  logic                      axi_rst,
  input  logic                      desc_valid,
  output logic                      desc_ready,
  input  logic [63:0]               desc_addr,
  input  logic [15:0]               desc_len_dw,
  output logic                      desc_done,
  input  logic [15:0]               cfg_req_id,
  input  logic [2:0]                cfg_mrrs,
  input  logic                      tag_free_valid,
  input  logic [TAG_WIDTH-1:0]      tag_free,
  output logic [TAG_WIDTH:0]        tags_in_use,
  output logic [AXI_DATA_WIDTH-1:0] s_axis_rr_tdata,
  output logic [BE_WIDTH-1:0]       s_axis_rr_tstrb,
  output logic                      s_axis_rr_tlast,
  output logic                      s_axis_rr_tvalid,
  output logic [USER_WIDTH_TX-1:0]  s_axis_rr_tuser,
  input  logic                      s_axis_rr_tready
);

  localparam int POOL = 1 << TAG_WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, SEND} state_t;

  state_t                 state;
  logic [63:0]            addr;
  logic [15:0]            rem_dw;
  logic [10:0]            chunk_dw;
  logic [POOL-1:0]        tag_map;
  logic [POOL-1:0]        tag_map_nxt;
  logic [2:0]             mrrs_eff;
  logic [10:0]            max_dw;
  logic [10:0]            bnd_dw;
  logic [10:0]            calc_dw;
  logic                   tag_avail;
  logic [TAG_WIDTH-1:0]   alloc_tag;
  logic                   alloc;
  logic                   four_dw;
  logic [31:0]            dw0;
  logic [31:0]            dw1;
  logic [127:0]           hdr;
  logic [TAG_WIDTH:0]     in_use;

  assign desc_ready       = (state == IDLE) && !axi_rst;
  assign s_axis_rr_tlast  = s_axis_rr_tvalid;
  assign alloc            = (state == CALC) && tag_avail;
  assign tags_in_use      = in_use;

  // Chunk size is the smallest of what remains, the MRRS limit and the room left in this 4 KB page.
  always_comb begin
    mrrs_eff = (cfg_mrrs > 3'd5) ? 3'd5 : cfg_mrrs;
    max_dw   = 11'd32 << mrrs_eff;
    bnd_dw   = 11'd1024 - {1'b0, addr[11:2]};
    calc_dw  = (max_dw < bnd_dw) ? max_dw : bnd_dw;
    if ({5'd0, calc_dw} > rem_dw) calc_dw = rem_dw[10:0];
  end

  always_comb begin
    tag_avail = 1'b0;
    alloc_tag = '0;
    for (int i = POOL - 1; i >= 0; i--) begin
      if (!tag_map[i]) begin
        tag_avail = 1'b1;
        alloc_tag = TAG_WIDTH'(i);
      end
    end
  end

  always_comb begin
    in_use = '0;
    for (int i = 0; i < POOL; i++) in_use = in_use + (TAG_WIDTH + 1)'(tag_map[i]);
  end

  // Free is applied before allocate so a same-cycle free of the allocated tag loses.
  always_comb begin
    tag_map_nxt = tag_map;
    if (tag_free_valid) tag_map_nxt[tag_free] = 1'b0;
    if (alloc) tag_map_nxt[alloc_tag] = 1'b1;
  end

  always_comb begin
    four_dw = |addr[63:32];
    dw0     = {(four_dw ? 3'b001 : 3'b000), 5'b00000, 14'd0, calc_dw[9:0]};
    dw1     = {cfg_req_id, 8'(alloc_tag), ((calc_dw > 11'd1) ? 4'hF : 4'h0), 4'hF};
    hdr     = four_dw ? {addr[31:2], 2'b00, addr[63:32], dw1, dw0}
                      : {32'd0, addr[31:2], 2'b00, dw1, dw0};
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) tag_map <= '0;
    else         tag_map <= tag_map_nxt;
  end

  always_ff @(posedge axi_clk) begin
    if (axi_rst) begin
      state            <= IDLE;
      addr             <= '0;
      rem_dw           <= '0;
      chunk_dw         <= '0;
      s_axis_rr_tvalid <= 1'b0;
      s_axis_rr_tdata  <= '0;
      s_axis_rr_tstrb  <= '0;
      s_axis_rr_tuser  <= '0;
      desc_done        <= 1'b0;
    end else begin
      desc_done <= 1'b0;
      case (state)
        IDLE: begin
          if (desc_valid) begin
            addr   <= desc_addr & ~64'd3;
            rem_dw <= desc_len_dw;
            if (desc_len_dw == 16'd0) desc_done <= 1'b1;
            else                      state     <= CALC;
          end
        end
        CALC: begin
          if (tag_avail) begin
            chunk_dw         <= calc_dw;
            s_axis_rr_tdata  <= AXI_DATA_WIDTH'(hdr);
            s_axis_rr_tstrb  <= BE_WIDTH'(four_dw ? 16'hFFFF : 16'h0FFF);
            s_axis_rr_tuser  <= USER_WIDTH_TX'(four_dw);
            s_axis_rr_tvalid <= 1'b1;
            state            <= SEND;
          end
        end
        SEND: begin
          if (s_axis_rr_tready) begin
            s_axis_rr_tvalid <= 1'b0;
            addr             <= addr + {51'd0, chunk_dw, 2'b00};
            rem_dw           <= rem_dw - {5'd0, chunk_dw};
            if (rem_dw == {5'd0, chunk_dw}) begin
              desc_done <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= CALC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_rd_req_gen.sv
// Directed self-checking bench for dma_rd_req_gen: chunking, 4 KB split, 64-bit headers,
// tag exhaustion/return, backpressure, maximum length and reset mid-transfer.
module tb_dma_rd_req_gen;

  localparam logic [15:0] REQ_ID = 16'hABCD;

  logic         clk;
  logic         axi_rst;
  logic         desc_valid;
  logic         desc_ready;
  logic [63:0]  desc_addr;
  logic [15:0]  desc_len_dw;
  logic         desc_done;
  logic [15:0]  cfg_req_id;
  logic [2:0]   cfg_mrrs;
  logic         tag_free_valid;
  logic [4:0]   tag_free;
  logic [5:0]   tags_in_use;
  logic [127:0] tdata;
  logic [15:0]  tstrb;
  logic         tlast;
  logic         tvalid;
  logic [3:0]   tuser;
  logic         tready;

  int total = 0;
  int bad   = 0;

  dma_rd_req_gen dut (
    .axi_clk          (clk),
    .axi_rst          (axi_rst),
    .desc_valid       (desc_valid),
    .desc_ready       (desc_ready),
    .desc_addr        (desc_addr),
    .desc_len_dw      (desc_len_dw),
    .desc_done        (desc_done),
    .cfg_req_id       (cfg_req_id),
    .cfg_mrrs         (cfg_mrrs),
    .tag_free_valid   (tag_free_valid),
    .tag_free         (tag_free),
    .tags_in_use      (tags_in_use),
    .s_axis_rr_tdata  (tdata),
    .s_axis_rr_tstrb  (tstrb),
    .s_axis_rr_tlast  (tlast),
    .s_axis_rr_tvalid (tvalid),
    .s_axis_rr_tuser  (tuser),
    .s_axis_rr_tready (tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, want);
    end
  endtask

  function automatic logic [127:0] exp_hdr(input logic [63:0] a, input int n, input int tag);
    logic [31:0] d0;
    logic [31:0] d1;
    logic        four;
    logic [9:0]  len;
    four = (a[63:32] != 32'd0);
    len  = n[9:0];
    d0   = {(four ? 3'b001 : 3'b000), 5'b00000, 14'd0, len};
    d1   = {REQ_ID, 8'(tag), ((n > 1) ? 4'hF : 4'h0), 4'hF};
    return four ? {a[31:2], 2'b00, a[63:32], d1, d0} : {32'd0, a[31:2], 2'b00, d1, d0};
  endfunction

  task automatic applyStimulus(input logic [63:0] a, input logic [15:0] len);
    checkOutput("desc_ready", desc_ready, 1);
    desc_valid  = 1'b1;
    desc_addr   = a;
    desc_len_dw = len;
    @(posedge clk); #1;
    desc_valid  = 1'b0;
  endtask

  task automatic freeTag(input int t);
    tag_free_valid = 1'b1;
    tag_free       = 5'(t);
    @(posedge clk); #1;
    tag_free_valid = 1'b0;
  endtask

  // Waits for a request, checks header and sideband, optionally stalls, then handshakes it.
  task automatic recvTlp(input logic [127:0] exp, input int exp_wait, input int stall, input bit last);
    int  waited;
    bit  four;
    waited = 0;
    while (!tvalid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!tvalid) begin
      checkOutput("tvalid_timeout", 0, 1);
      return;
    end
    if (exp_wait >= 0) checkOutput("latency", waited, exp_wait);
    four = (exp[31:29] == 3'b001);
    checkOutput("tdata", tdata, exp);
    checkOutput("tstrb", tstrb, four ? 16'hFFFF : 16'h0FFF);
    checkOutput("tuser", tuser, {3'b000, four});
    checkOutput("tlast", tlast, 1);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      checkOutput("hold_tvalid", tvalid, 1);
      checkOutput("hold_tdata", tdata, exp);
      checkOutput("hold_tstrb", tstrb, four ? 16'hFFFF : 16'h0FFF);
    end
    tready = 1'b1;
    @(posedge clk); #1;
    tready = 1'b0;
    checkOutput("desc_done", desc_done, last);
    if (last) begin
      @(posedge clk); #1;
      checkOutput("desc_done_pulse", desc_done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    axi_rst        = 1'b1;
    desc_valid     = 1'b0;
    desc_addr      = '0;
    desc_len_dw    = '0;
    cfg_req_id     = REQ_ID;
    cfg_mrrs       = 3'd0;
    tag_free_valid = 1'b0;
    tag_free       = '0;
    tready         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", tvalid, 0);
    checkOutput("rst_tdata", tdata, 0);
    checkOutput("rst_tstrb", tstrb, 0);
    checkOutput("rst_tuser", tuser, 0);
    checkOutput("rst_desc_done", desc_done, 0);
    checkOutput("rst_tags_in_use", tags_in_use, 0);
    checkOutput("rst_desc_ready", desc_ready, 0);
    axi_rst = 1'b0;
    @(posedge clk); #1;

    // Zero-length descriptor: done pulse only
    applyStimulus(64'h500, 16'd0);
    checkOutput("len0_done", desc_done, 1);
    checkOutput("len0_tvalid", tvalid, 0);
    @(posedge clk); #1;
    checkOutput("len0_done_pulse", desc_done, 0);
    checkOutput("len0_tvalid2", tvalid, 0);

    // Test 1: single 3DW request
    cfg_mrrs = 3'd2;
    applyStimulus(64'h1000, 16'd16);
    checkOutput("t1_tvalid_early", tvalid, 0);
    recvTlp({32'h0000_0000, 32'h0000_1000, 16'hABCD, 8'h00, 8'hFF, 32'h0000_0010}, 1, 0, 1);
    checkOutput("t1_tags_in_use", tags_in_use, 1);
    freeTag(0);
    checkOutput("t1_tags_freed", tags_in_use, 0);

    // Test 2: 4 KB crossing; MRRS code 7 clamps to 1024 DW
    cfg_mrrs = 3'd7;
    applyStimulus(64'hF80, 16'd64);
    recvTlp(exp_hdr(64'hF80, 32, 0), 1, 0, 0);
    recvTlp(exp_hdr(64'h1000, 32, 1), 1, 0, 1);
    freeTag(0);
    freeTag(1);

    // Test 3 + backpressure: 4DW headers, second TLP stalled 5 cycles
    cfg_mrrs = 3'd1;
    applyStimulus(64'h1_0000_0000, 16'd300);
    for (int i = 0; i < 4; i++)
      recvTlp(exp_hdr(64'h1_0000_0000 + 64'(i * 256), 64, i), 1, (i == 1) ? 5 : 0, 0);
    recvTlp({32'h0000_0400, 32'h0000_0001, 16'hABCD, 8'h04, 8'hFF, 32'h2000_002C}, 1, 0, 1);
    checkOutput("t3_tags_in_use", tags_in_use, 5);
    for (int i = 0; i < 5; i++) freeTag(i);

    // Test 4: tag exhaustion and return
    cfg_mrrs = 3'd0;
    applyStimulus(64'h0, 16'd1056);
    for (int i = 0; i < 32; i++) recvTlp(exp_hdr(64'(i * 128), 32, i), 1, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t4_stall_tvalid", tvalid, 0);
    checkOutput("t4_full", tags_in_use, 32);
    freeTag(7);
    recvTlp(exp_hdr(64'h1000, 32, 7), 1, 0, 1);
    checkOutput("t4_full_after", tags_in_use, 32);
    for (int i = 0; i < 32; i++) freeTag(i);
    checkOutput("t4_all_free", tags_in_use, 0);
    freeTag(3);
    checkOutput("t4_double_free", tags_in_use, 0);

    // Single-DW request has LastBE 0
    applyStimulus(64'h40, 16'd1);
    recvTlp({32'h0, 32'h0000_0040, 16'hABCD, 8'h00, 8'h0F, 32'h0000_0001}, 1, 0, 1);
    freeTag(0);

    // Test 6: maximum length encodes as Length 0
    cfg_mrrs = 3'd6;
    applyStimulus(64'h2000, 16'd1024);
    recvTlp({32'h0, 32'h0000_2000, 16'hABCD, 8'h00, 8'hFF, 32'h0000_0000}, 1, 0, 1);
    freeTag(0);

    // Reset while a request is pending
    cfg_mrrs = 3'd5;
    applyStimulus(64'h3000, 16'd64);
    waited = 0;
    while (!tvalid && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("rst_pre_tvalid", tvalid, 1);
    checkOutput("rst_pre_tags", tags_in_use, 1);
    axi_rst = 1'b1;
    #1;
    checkOutput("rst_mid_desc_ready", desc_ready, 0);
    @(posedge clk); #1;
    checkOutput("rst_mid_tvalid", tvalid, 0);
    checkOutput("rst_mid_tags", tags_in_use, 0);
    checkOutput("rst_mid_done", desc_done, 0);
    axi_rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_post_desc_ready", desc_ready, 1);
    checkOutput("rst_post_done", desc_done, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_post_tvalid", tvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dma_rd_req_gen.md
Name: dma_rd_req_gen

Overview:
- Runs in the DMA read path, directly upstream of the PCIe TLP bridge's AXIS Read-Request slave port (s_axis_rr_*).
- Accepts read descriptors (address, length in DW) and splits each into Memory Read TLPs.
- Chunking honours programmed MRRS and never crosses a 4 KB address boundary.
- Assigns tags from a 32-entry free pool; completion logic returns tags.

Parameters:
- AXI_DATA_WIDTH, 128, TLP beat width (only 128 supported).
- BE_WIDTH, AXI_DATA_WIDTH/8, strobe width.
- USER_WIDTH_TX, 4, tuser width on s_axis_rr.
- TAG_WIDTH, 5, tag bits (pool size 2**TAG_WIDTH).

Ports:
- axi_clk  in  1  clock
- axi_rst  in  1  reset
- desc_valid  in  1  descriptor valid
- desc_ready  out  1  descriptor accept
- desc_addr  in  64  byte address; bits[1:0] ignored (DW aligned)
- desc_len_dw  in  16  length in DW
- desc_done  out  1  one-cycle pulse after last TLP of a descriptor handshakes
- cfg_req_id  in  16  requester ID
- cfg_mrrs  in  3  MRRS code n: 128<<n bytes; codes >5 clamp to 5
- tag_free_valid  in  1  return tag strobe
- tag_free  in  TAG_WIDTH  tag being returned
- tags_in_use  out  TAG_WIDTH+1  count of allocated tags
- s_axis_rr_tdata  out  AXI_DATA_WIDTH  TLP header
- s_axis_rr_tstrb  out  BE_WIDTH  valid bytes
- s_axis_rr_tlast  out  1  always 1 when tvalid
- s_axis_rr_tvalid  out  1  request valid
- s_axis_rr_tuser  out  USER_WIDTH_TX  [0]=4DW header, others 0
- s_axis_rr_tready  in  1  downstream ready

Behaviour:
- Interface: one clock, axi_clk; reset axi_rst is synchronous, active-high.
- Reset values:
  - tvalid=0, tdata/tstrb/tuser=0
  - desc_done=0, tags_in_use=0
  - all tags free, state IDLE
  - desc_ready=0 while axi_rst=1.
- FSM IDLE -> CALC -> SEND -> (CALC | IDLE).
- IDLE:
  - desc_ready=1.
  - On desc_valid&&desc_ready: latch addr/len, go to CALC.
  - len 0: no TLP; pulse desc_done next cycle, stay IDLE.
- CALC (one cycle minimum):
  - chunk_dw = min(rem_dw, 32<<n, 1024-addr[11:2]).
  - Waits here while no tag is free.
  - When a tag is free, allocate the lowest-numbered free tag, register the header, go to SEND.
- SEND:
  - tvalid=1; tdata/tstrb/tuser held stable until tready.
  - On handshake: addr += chunk_dw*4, rem_dw -= chunk_dw.
  - If rem_dw becomes 0: go to IDLE with desc_done pulsed that cycle+1. Otherwise go to CALC.
- Latency:
  - Descriptor accept at cycle T gives tvalid at T+2 (tag free).
  - Between TLPs of one descriptor: handshake at M, next tvalid at M+2.
- Header layout (DW0 in tdata[31:0]):
  - DW0: Fmt = 3'b000 if addr[63:32]==0, else 3'b001; Type 5'b00000; TC/attr/TD/EP 0; Length[9:0] = chunk_dw (1024 encodes as 0).
  - DW1: {cfg_req_id, 8'(tag), LastBE, FirstBE}. FirstBE=4'hF. LastBE=4'hF if chunk_dw>1, else 4'h0.
  - 3DW header: DW2 = addr[31:2],2'b00; tstrb=16'h0FFF; tuser[0]=0; DW3=0.
  - 4DW header: DW2 = addr[63:32]; DW3 = addr[31:2],2'b00; tstrb=16'hFFFF; tuser[0]=1.
- Tag pool:
  - Bitmap; tags_in_use = popcount.
  - Allocation and tag_free on the same cycle are both applied.
  - Freeing the same tag being allocated that cycle: the allocation wins (tag stays in use).
  - Freeing an already-free tag: ignored.
- cfg_mrrs/cfg_req_id are sampled in CALC; changes mid-descriptor affect following chunks only.
- Reset mid-operation:
  - Drops tvalid in the next cycle; the in-flight TLP is abandoned.
  - Tag bitmap clears; the descriptor is discarded.
  - No desc_done.

Test Plan:
1. addr 0x1000, len 16, cfg_mrrs=2 -> one TLP with:
   - DW0=0x00000010, DW1={req_id,8'h00,8'hFF}, DW2=0x00001000
   - tstrb 0x0FFF, tuser 0, tlast 1; desc_done pulses once.
2. 4 KB crossing: addr 0xF80, len 64, cfg_mrrs=5 -> TLP 32 DW @0xF80 tag0, then 32 DW @0x1000 tag1.
3. 64-bit split: addr 0x1_0000_0000, len 300, cfg_mrrs=1 -> four 64-DW TLPs plus one 44-DW TLP:
   - DW2=0x00000001, tstrb 0xFFFF, tuser[0]=1, tags 0..4.
   - Last chunk addr low 0x400.
4. Tag exhaustion: addr 0, len 1056, cfg_mrrs=0:
   - 32 TLPs, tags 0..31; then stall with tags_in_use=32.
   - tag_free=7 -> 33rd TLP (32 DW @0x1000) uses tag 7 two cycles later.
   - 1-DW check: len 1 gives DW1[7:0]=8'h0F.
5. Backpressure: tready low 5 cycles during SEND -> tdata/tstrb/tuser unchanged; address advances only on the handshake.
6. Max length: addr 0x2000, len 1024, cfg_mrrs=5 -> one TLP with Length field 0. Then assert axi_rst mid-SEND of a new descriptor:
   - tvalid=0 and tags_in_use=0 after reset.
   - desc_ready=1 after release.
